// File: rtl/fb_pixel_sink_if.sv
// Pixel-write and row-scan handshakes of the frame-buffer sink.
interface fb_pixel_sink_if #(
    parameter int DIM = 64,
    parameter int CW  = 6
);
    logic           pix_valid;
    logic           pix_ready;
    logic [CW-1:0]  pix_x;
    logic [CW-1:0]  pix_y;
    logic           row_valid;
    logic           row_ready;
    logic [CW-1:0]  row_idx;
    logic [DIM-1:0] row_data;

    // Rasterizer / display side.
    modport master (
        output pix_valid, pix_x, pix_y, row_ready,
        input  pix_ready, row_valid, row_idx, row_data
    );

    // Frame-buffer sink side.
    modport slave (
        input  pix_valid, pix_x, pix_y, row_ready,
        output pix_ready, row_valid, row_idx, row_data
    );
endinterface

// File: rtl/fb_pixel_sink.sv
// One-bit DIM x DIM frame buffer: accepts pixel writes, clears row by row,
// scans rows out, and counts distinct lit pixels.
module fb_pixel_sink #(
    parameter int DIM = 64,
    parameter int CW  = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    fb_pixel_sink_if.slave       bus,
    input  logic                 clear,
    input  logic                 scan_start,
    output logic                 scan_done,
    output logic                 busy,
    output logic [2*CW:0]        pix_count
);
    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

    state_t          state, state_next;
    logic [DIM-1:0]  fb [DIM];
    logic [CW-1:0]   row_idx;
    logic [CW-1:0]   clr_row;
    logic            write_en;
    logic            clear_go;
    logic            row_adv;

    assign busy         = (state != IDLE);
    assign bus.row_idx  = row_idx;
    assign bus.row_data = fb[row_idx];

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state;
        bus.pix_ready = 1'b0;
        bus.row_valid = 1'b0;
        scan_done     = 1'b0;
        write_en      = 1'b0;
        clear_go      = 1'b0;
        row_adv       = 1'b0;
        case (state)
            IDLE: begin
                bus.pix_ready = !clear;
                write_en      = bus.pix_valid && !clear;
                if (clear) begin
                    clear_go   = 1'b1;
                    state_next = CLEAR;
                end else if (scan_start) begin
                    state_next = SCAN;
                end
            end
            CLEAR: begin
                if (clr_row == CW'(DIM-1)) state_next = IDLE;
            end
            SCAN: begin
                bus.row_valid = 1'b1;
                if (bus.row_ready) begin
                    row_adv = 1'b1;
                    if (row_idx == CW'(DIM-1)) state_next = DONE;
                end
            end
            DONE: begin
                scan_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Scan row pointer; incrementing past DIM-1 wraps to 0 for DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                             row_idx <= '0;
        else if (state == IDLE && !clear && scan_start) row_idx <= '0;
        else if (row_adv)                       row_idx <= row_idx + CW'(1);
    end

    // Clear row pointer, restarting at 0 every time CLEAR is entered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)              clr_row <= '0;
        else if (state == CLEAR) clr_row <= clr_row + CW'(1);
        else                     clr_row <= '0;
    end

    // Frame buffer: pixel sets in IDLE, one row zeroed per CLEAR cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned r = 0; r < DIM; r++) fb[r] <= '0;
        end else if (state == CLEAR) begin
            fb[clr_row] <= '0;
        end else if (write_en) begin
            fb[bus.pix_y][bus.pix_x] <= 1'b1;
        end
    end

    // Distinct-pixel count; zeroed on the edge entering CLEAR so it reads 0
    // throughout the clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            pix_count <= '0;
        else if (clear_go)
            pix_count <= '0;
        else if (write_en && !fb[bus.pix_y][bus.pix_x])
            pix_count <= pix_count + (2*CW+1)'(1);
    end
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Self-checking bench for fb_pixel_sink: directed scenarios plus random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_fb_pixel_sink;
    localparam int DIM = 64;
    localparam int CW  = 6;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        clear = 1'b0;
    logic        scan_start = 1'b0;
    logic        scan_done;
    logic        busy;
    logic [12:0] pix_count;

    fb_pixel_sink_if #(.DIM(DIM), .CW(CW)) bus ();

    fb_pixel_sink #(.DIM(DIM), .CW(CW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus.slave),
        .clear      (clear),
        .scan_start (scan_start),
        .scan_done  (scan_done),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame as array of rows, activity as remaining counts.
    bit [63:0] mfb [64];
    int        clr_left = 0;    // >0: clearing, cycles remaining
    int        scan_row = -1;   // >=0: row currently presented
    bit        done_cyc = 1'b0;
    logic [63:0] cap [64];      // rows accepted by the consumer in the last scan

    function automatic bit m_idle();
        return (clr_left == 0) && (scan_row < 0) && !done_cyc;
    endfunction

    function automatic int m_count();
        int c = 0;
        if (clr_left > 0) return 0;
        for (int r = 0; r < 64; r++) c += $countones(mfb[r]);
        return c;
    endfunction

    initial begin
        for (int r = 0; r < 64; r++) mfb[r] = '0;
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                for (int r = 0; r < 64; r++) mfb[r] = '0;
                clr_left = 0;
                scan_row = -1;
                done_cyc = 1'b0;
            end else if (clr_left > 0) begin
                mfb[64 - clr_left] = '0;
                clr_left--;
            end else if (scan_row >= 0) begin
                if (bus.row_ready) begin
                    if (scan_row == 63) begin
                        scan_row = -1;
                        done_cyc = 1'b1;
                    end else begin
                        scan_row++;
                    end
                end
            end else if (done_cyc) begin
                done_cyc = 1'b0;
            end else if (clear) begin
                clr_left = 64;
            end else begin
                if (bus.pix_valid) mfb[bus.pix_y][bus.pix_x] = 1'b1;
                if (scan_start) scan_row = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, !m_idle());
            check("pix_ready", bus.pix_ready, m_idle() && !clear);
            check("row_valid", bus.row_valid, scan_row >= 0);
            check("row_idx", bus.row_idx, (scan_row >= 0) ? scan_row : 0);
            check("scan_done", scan_done, done_cyc);
            check("pix_count", pix_count, m_count());
            if (scan_row >= 0) check("row_data", bus.row_data, mfb[scan_row]);
            if (bus.row_valid && bus.row_ready) cap[bus.row_idx] = bus.row_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int x, input int y);
        bus.pix_valid = 1'b1;
        bus.pix_x = CW'(x);
        bus.pix_y = CW'(y);
        #1;
        check("write_ready", bus.pix_ready, 1'b1);
        step();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Full scan with row_ready high; n = cycles from scan_start to scan_done.
    task automatic do_scan(input string name, output int n);
        scan_start = 1'b1;
        bus.row_ready = 1'b1;
        step();
        scan_start = 1'b0;
        n = 1;
        while (!scan_done && n < 200) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, scan_done, 1'b1);
        check({name, "_busy_in_done"}, busy, 1'b1);
        step();
        check({name, "_busy_after"}, busy, 1'b0);
    endtask

    function automatic int nonzero_rows();
        int c = 0;
        for (int r = 0; r < 64; r++) if (cap[r] !== 64'h0) c++;
        return c;
    endfunction

    initial begin
        int n;
        logic [63:0] one;
        logic [63:0] top;
        one = 64'h1;
        top = 64'h8000_0000_0000_0000;
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.row_ready = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_row_valid", bus.row_valid, 1'b0);
        check("rst_count", pix_count, 0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_row_idx", bus.row_idx, 0);
        #2 n_rst = 1'b1;
        step();

        // Repeated pixel counts once.
        write_px(3, 5);
        write_px(3, 5);
        write_px(63, 63);
        bus.pix_valid = 1'b0;
        check("count_dup", pix_count, 2);
        do_scan("scan1", n);
        check("row5", cap[5], 64'h8);
        check("row63", cap[63], top);
        check("scan1_lit_rows", nonzero_rows(), 2);

        // Diagonal and scan latency.
        pulse_clear();
        wait_idle("clr1", 100);
        for (int k = 0; k < 8; k++) write_px(k, k);
        bus.pix_valid = 1'b0;
        check("diag_count", pix_count, 8);
        do_scan("scan2", n);
        check("scan_latency", n, 65);
        for (int k = 0; k < 8; k++) check("diag_row", cap[k], one << k);
        check("scan2_lit_rows", nonzero_rows(), 8);

        // Stall at row 12; writes refused during scan.
        scan_start = 1'b1;
        bus.row_ready = 1'b1;
        step();
        scan_start = 1'b0;
        n = 0;
        while (bus.row_idx != 12 && n < 100) begin
            step();
            n++;
        end
        check("reach_row12", bus.row_idx, 12);
        bus.row_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = (i % 2 == 0);
            bus.pix_x = CW'($urandom_range(0, 63));
            bus.pix_y = CW'($urandom_range(0, 63));
            #1;
            check("stall_ready", bus.pix_ready, 1'b0);
            check("stall_idx", bus.row_idx, 12);
            check("stall_valid", bus.row_valid, 1'b1);
            step();
        end
        bus.pix_valid = 1'b0;
        bus.row_ready = 1'b1;
        n = 0;
        while (!scan_done && n < 100) begin
            step();
            n++;
        end
        check("stall_done", scan_done, 1'b1);
        step();
        check("stall_row7", cap[7], 64'h80);
        check("stall_count", pix_count, 8);

        // 100 distinct pixels then a timed clear.
        pulse_clear();
        wait_idle("clr2", 100);
        for (int i = 0; i < 100; i++) write_px(i % 64, 10 + i / 64);
        bus.pix_valid = 1'b0;
        check("count100", pix_count, 100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_first_count", pix_count, 0);
        n = 1;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("clear_busy_cycles", n - 1, 64);
        do_scan("scan3", n);
        check("scan3_lit_rows", nonzero_rows(), 0);

        // clear beats scan_start and a write.
        bus.pix_valid = 1'b1;
        bus.pix_x = CW'(1);
        bus.pix_y = CW'(1);
        clear = 1'b1;
        scan_start = 1'b1;
        #1;
        check("prio_ready", bus.pix_ready, 1'b0);
        step();
        clear = 1'b0;
        scan_start = 1'b0;
        bus.pix_valid = 1'b0;
        check("prio_clearing", busy, 1'b1);
        check("prio_no_scan", bus.row_valid, 1'b0);
        wait_idle("clr3", 100);
        check("prio_model_px", mfb[1][1], 1'b0);
        do_scan("scan4", n);
        check("prio_row1", cap[1], 64'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.pix_x = CW'($urandom_range(0, 63));
            bus.pix_y = CW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3));
            clear = ($urandom_range(0, 299) == 0);
            scan_start = ($urandom_range(0, 79) == 0);
            bus.row_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.pix_valid = 1'b0;
        clear = 1'b0;
        scan_start = 1'b0;
        bus.row_ready = 1'b1;
        wait_idle("rand", 300);

        // Reset in the middle of a scan.
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        n = 0;
        while (bus.row_idx != 30 && n < 100) begin
            step();
            n++;
        end
        check("reach_row30", bus.row_idx, 30);
        #3 n_rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.row_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", pix_count, 0);
        check("mid_rst_idx", bus.row_idx, 0);
        step();
        step();
        #2 n_rst = 1'b1;
        step();
        do_scan("scan5", n);
        check("scan5_lit_rows", nonzero_rows(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
